// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch slice.
//   fetch_entry_t : one buffered {pc, instr} pair
//   fetch_state_t : sequencer FSM states
//   XLEN          : PC / datapath width; fixed here because fetch_entry_t depends on it
//   INSTR_NOP     : canonical RV32I nop (addi x0,x0,0)
package fetch_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {BOOT, FETCH, HALT} fetch_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  // Redirect targets are byte addresses; the low two bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch sequencer's bus signals.
//   imem_addr/imem_instr        : combinational instruction-memory port
//   redirect_valid/redirect_pc  : taken branch/jump from decode or branch unit
//   out_valid/out_ready/out_pc/out_instr : fetch -> decode valid/ready stream
//   done                        : fetch stopped at end of memory
// master = fetch_sequencer side, slave = memory/decode/branch side.
interface fetch_if;
  import fetch_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_instr;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic            done;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, done,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, done,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry buffer of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear (pointers and count to zero)
//   push/wdata : write one entry; accepted when not full, or full with a pop
//   pop        : advance head (ignored when empty)
//   rdata      : head entry, read straight from storage registers
//   empty/full : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // When full, a same-cycle pop frees the slot being written.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: RV32I instruction-fetch controller.
// Owns the fetch PC, addresses the combinational instruction memory, and
// buffers {pc, instr} pairs for decode. A redirect flushes the buffer and
// reloads the PC; it takes priority over push and pop in the same cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : fetch_if.master (imem port, redirect, decode stream, done)
// Optional macro FETCH_BOUND_EN: stop fetching once the word address reaches
// IMEM_DEPTH (HALT state, done=1 when drained); without it fetch runs on
// past the end of memory and done is tied 0.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_DEPTH = 18,
  parameter int              BUF_DEPTH  = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  fetch_if.master bus
);
  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  fetch_entry_t    head;
  logic            fifo_empty, fifo_full;
  logic            pop, push, fetch_in_range;

`ifdef FETCH_BOUND_EN
  logic redir_in_range;
  assign fetch_in_range = (fetch_pc >> 2) < XLEN'(IMEM_DEPTH);
  assign redir_in_range = (bus.redirect_pc >> 2) < XLEN'(IMEM_DEPTH);
`else
  assign fetch_in_range = 1'b1;
`endif

  assign bus.imem_addr = fetch_pc >> 2;
  assign pop  = bus.out_valid & bus.out_ready;
  assign push = (state == FETCH) & ~bus.redirect_valid & fetch_in_range
              & (~fifo_full | pop);

  // PC and state in one register block; redirect overrides any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
    end else begin
      if (bus.redirect_valid) fetch_pc <= align_pc(bus.redirect_pc);
      else if (push)          fetch_pc <= fetch_pc + XLEN'(4);

      unique case (state)
        BOOT:  state <= FETCH;
`ifdef FETCH_BOUND_EN
        // An out-of-range redirect target lands here one cycle later.
        FETCH: if (!bus.redirect_valid && !fetch_in_range) state <= HALT;
        HALT:  if (bus.redirect_valid && redir_in_range)   state <= FETCH;
`else
        FETCH: state <= FETCH;
        HALT:  state <= FETCH;
`endif
        default: state <= BOOT;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push),
    .wdata ('{pc: fetch_pc, instr: bus.imem_instr}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

`ifdef FETCH_BOUND_EN
  assign bus.done = (state == HALT) & fifo_empty;
`else
  assign bus.done = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench for fetch_sequencer.
// Instruction memory model returns word k = k, so every accepted entry must
// carry instr == pc >> 2. Expected pcs are queued per scenario and popped on
// each accepted handshake. Second instance (bus2) starts at 0xFFFFFFF8.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_if bus2 ();

  assign bus.imem_instr  = bus.imem_addr;
  assign bus2.imem_instr = bus2.imem_addr;

  fetch_sequencer #(.RESET_PC(32'h0), .IMEM_DEPTH(18), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  fetch_sequencer #(.RESET_PC(32'hFFFF_FFF8), .IMEM_DEPTH(18), .BUF_DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  // Holds reset across two edges; leaves rst_n low, 1ns after a posedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", bus.out_pc); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL rst_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
    checks++; if (bus2.imem_addr !== 32'h3FFF_FFFE) begin failures++; $display("FAIL rst_addr2 got=%h exp=3ffffffe", bus2.imem_addr); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k * 4));
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== (c >= 2)) begin failures++; $display("FAIL t1_valid c=%0d got=%b exp=%b", c, bus.out_valid, (c >= 2)); end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL t1_extra got=%h exp=none", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          checks++; if (bus.out_pc !== e) begin failures++; $display("FAIL t1_pc got=%h exp=%h", bus.out_pc, e); end
          checks++; if (bus.out_instr !== (e >> 2)) begin failures++; $display("FAIL t1_instr got=%h exp=%h", bus.out_instr, e >> 2); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t1_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(32'(k * 4));
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        checks++; if (bus.imem_addr !== 32'd1) begin failures++; $display("FAIL t2_addr1 got=%h exp=1", bus.imem_addr); end
      end
      if (c >= 3) begin
        checks++; if (bus.imem_addr !== 32'd2) begin failures++; $display("FAIL t2_addr_hold c=%0d got=%h exp=2", c, bus.imem_addr); end
        checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL t2_head c=%0d got=%h exp=0", c, bus.out_pc); end
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t2_gap k=%0d got=%b exp=1", k, bus.out_valid); end
      if (bus.out_valid) begin
        e = exp_q.pop_front();
        checks++; if (bus.out_pc !== e) begin failures++; $display("FAIL t2_pc got=%h exp=%h", bus.out_pc, e); end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'h1C);
    exp_q.push_back(32'h20);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      bus.out_ready = (c != 4);
      bus.redirect_valid = (c == 5);
      bus.redirect_pc = (c == 5) ? 32'h1E : 32'h0;
      if (c == 5) begin
        checks++; if (bus.imem_addr !== 32'd4) begin failures++; $display("FAIL t3_full_addr got=%h exp=4", bus.imem_addr); end
      end
      if (c == 6) begin
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t3_flush got=%b exp=0", bus.out_valid); end
        checks++; if (bus.imem_addr !== 32'd7) begin failures++; $display("FAIL t3_addr got=%h exp=7", bus.imem_addr); end
      end
      if (c == 7) begin
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t3_resume got=%b exp=1", bus.out_valid); end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL t3_extra got=%h exp=none", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          checks++; if (bus.out_pc !== e) begin failures++; $display("FAIL t3_pc c=%0d got=%h exp=%h", c, bus.out_pc, e); end
        end
      end
    end
    bus.redirect_valid = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t3_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL t4_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL t4_addr got=%h exp=0", bus.imem_addr); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== (c >= 2)) begin failures++; $display("FAIL t4_restart c=%0d got=%b exp=%b", c, bus.out_valid, (c >= 2)); end
      if (bus.out_valid && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if (bus.out_pc !== e) begin failures++; $display("FAIL t4_pc got=%h exp=%h", bus.out_pc, e); end
      end
    end
  endtask

  task automatic test_bound();
    apply_reset();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
`ifdef FETCH_BOUND_EN
    for (int k = 0; k < 18; k++) exp_q.push_back(32'(k * 4));
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 10) begin
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL t5_early_done got=%b exp=0", bus.done); end
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL t5_extra got=%h exp=none", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          checks++; if (bus.out_pc !== e) begin failures++; $display("FAIL t5_pc got=%h exp=%h", bus.out_pc, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t5_left got=%0d exp=0", exp_q.size()); end
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL t5_done got=%b exp=1", bus.done); end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL t5_undone got=%b exp=0", bus.done); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL t5_rvalid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin failures++; $display("FAIL t5_rpc got=%h exp=0", bus.out_pc); end
`else
    // Without the bound, fetch runs past word 17 and done never rises.
    for (int k = 0; k < 21; k++) exp_q.push_back(32'(k * 4));
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk); #1;
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL t5_done c=%0d got=%b exp=0", c, bus.done); end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL t5_extra got=%h exp=none", bus.out_pc); end
        else begin
          e = exp_q.pop_front();
          checks++; if (bus.out_pc !== e) begin failures++; $display("FAIL t5_pc got=%h exp=%h", bus.out_pc, e); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t5_left got=%0d exp=0", exp_q.size()); end
`endif
  endtask

  task automatic test_wrap();
    apply_reset();
    rst_n = 1'b1;
`ifndef FETCH_BOUND_EN
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus2.out_valid !== (c >= 2)) begin failures++; $display("FAIL t6_valid c=%0d got=%b exp=%b", c, bus2.out_valid, (c >= 2)); end
      if (bus2.out_valid && bus2.out_ready) begin
        if (exp_q.size() == 0) begin checks++; failures++; $display("FAIL t6_extra got=%h exp=none", bus2.out_pc); end
        else begin
          e = exp_q.pop_front();
          checks++; if (bus2.out_pc !== e) begin failures++; $display("FAIL t6_pc got=%h exp=%h", bus2.out_pc, e); end
          checks++; if (bus2.out_instr !== (e >> 2)) begin failures++; $display("FAIL t6_instr got=%h exp=%h", bus2.out_instr, e >> 2); end
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL t6_left got=%0d exp=0", exp_q.size()); end
`else
    // Start address is already beyond memory: nothing is ever fetched.
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      checks++; if (bus2.out_valid !== 1'b0) begin failures++; $display("FAIL t6_valid c=%0d got=%b exp=0", c, bus2.out_valid); end
    end
    checks++; if (bus2.done !== 1'b1) begin failures++; $display("FAIL t6_done got=%b exp=1", bus2.done); end
`endif
  endtask

  initial begin
    bus2.out_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = '0;
    test_reset();
    test_backpressure();
    test_redirect();
    test_async_reset();
    test_bound();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
